// File: rtl/sd_disk_loader.sv
// sd_disk_loader: moves floppy tracks and HDD blocks between the hps_io SD
// interface and the core's track buffer / HDD controller.
//   clk_sys, reset_n       : system clock, async active-low reset
//   img_mounted/readonly/size : hps_io mount strobes and image attributes
//   track                  : floppy head track requested by the drive emulation
//   hdd_sector/read/write  : HDD block number and single-cycle request pulses
//   sd_ack                 : hps_io per-sector transfer acknowledge
//   sd_lba, sd_rd, sd_wr   : SD block address and per-drive requests (bit0 FDD, bit1 HDD)
//   track_sec              : sector index within the track buffer
//   cpu_wait               : CPU stall while a transfer is in flight
//   hdd_mounted/protect    : HDD mount and write-protect status
// Build option: define SD_DISK_HDD_EN to include the HDD path.
module sd_disk_loader #(
  parameter int unsigned SECTORS_PER_TRACK = 13
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [1:0]  img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  input  logic [5:0]  track,
  input  logic [15:0] hdd_sector,
  input  logic        hdd_read,
  input  logic        hdd_write,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  output logic [3:0]  track_sec,
  output logic        cpu_wait,
  output logic        hdd_mounted,
  output logic        hdd_protect
);

  localparam logic [3:0]  LAST_SEC = 4'(SECTORS_PER_TRACK - 1);
  localparam logic [31:0] SPT      = 32'(SECTORS_PER_TRACK);

`ifdef SD_DISK_HDD_EN
  typedef enum logic [1:0] {IDLE, FDD_LOAD, HDD_REQ, HDD_DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, FDD_LOAD} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] lba_q, lba_d;
  logic        fdd_rd_q, fdd_rd_d;
  logic [3:0]  tsec_q, tsec_d;
  logic        wait_q, wait_d;
  logic [5:0]  cur_track_q, cur_track_d;
  logic        armed_q, armed_d;
  logic        ack_q;

  logic ack_rise, ack_fall, fdd_trig;
  assign ack_rise = sd_ack & ~ack_q;
  assign ack_fall = ~sd_ack & ack_q;
  // A load is due on a track mismatch or once the floppy mount strobe has dropped.
  assign fdd_trig = (cur_track_q != track) | (armed_q & ~img_mounted[0]);

`ifdef SD_DISK_HDD_EN
  logic hdd_rd_q, hdd_rd_d;
  logic hdd_wr_q, hdd_wr_d;
  logic rd_pend_q, rd_pend_d;
  logic wr_pend_q, wr_pend_d;
  logic serve_wr_q, serve_wr_d;
  logic hdd_mnt_q, hdd_mnt_d;
  logic hdd_prot_q, hdd_prot_d;
  logic rd_clr, wr_clr;

  assign sd_rd       = {hdd_rd_q, fdd_rd_q};
  assign sd_wr       = {hdd_wr_q, 1'b0};
  assign hdd_mounted = hdd_mnt_q;
  assign hdd_protect = hdd_prot_q;
`else
  logic unused_hdd;
  assign unused_hdd  = ^{hdd_sector, hdd_read, hdd_write, img_readonly, img_mounted[1]};
  assign sd_rd       = {1'b0, fdd_rd_q};
  assign sd_wr       = 2'b00;
  assign hdd_mounted = 1'b0;
  assign hdd_protect = 1'b0;
`endif

  assign sd_lba    = lba_q;
  assign track_sec = tsec_q;
  assign cpu_wait  = wait_q;

  // Next-state and next-register values.
  always_comb begin
    state_d     = state_q;
    lba_d       = lba_q;
    fdd_rd_d    = fdd_rd_q;
    tsec_d      = tsec_q;
    wait_d      = wait_q;
    cur_track_d = cur_track_q;
    armed_d     = armed_q | img_mounted[0];
`ifdef SD_DISK_HDD_EN
    hdd_rd_d    = hdd_rd_q;
    hdd_wr_d    = hdd_wr_q;
    serve_wr_d  = serve_wr_q;
    hdd_mnt_d   = hdd_mnt_q;
    hdd_prot_d  = hdd_prot_q;
    rd_clr      = 1'b0;
    wr_clr      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
`ifdef SD_DISK_HDD_EN
        if (rd_pend_q) begin
          lba_d      = {16'h0, hdd_sector};
          hdd_rd_d   = 1'b1;
          wait_d     = 1'b1;
          serve_wr_d = 1'b0;
          state_d    = HDD_REQ;
        end else if (wr_pend_q) begin
          lba_d      = {16'h0, hdd_sector};
          hdd_wr_d   = 1'b1;
          wait_d     = 1'b1;
          serve_wr_d = 1'b1;
          state_d    = HDD_REQ;
        end else
`endif
        if (fdd_trig) begin
          cur_track_d = track;
          // Consumes a pending mount edge; stays armed if the strobe is still high.
          armed_d     = img_mounted[0];
          if (img_size != 64'd0) begin
            lba_d    = 32'(track) * SPT;
            tsec_d   = 4'd0;
            fdd_rd_d = 1'b1;
            wait_d   = 1'b1;
            state_d  = FDD_LOAD;
          end
        end
      end

      FDD_LOAD: begin
        // Request drops at the start of the last sector; finish on its ack fall.
        if (ack_rise) begin
          lba_d = lba_q + 32'd1;
          if (tsec_q >= LAST_SEC) fdd_rd_d = 1'b0;
        end
        if (ack_fall) begin
          tsec_d = tsec_q + 4'd1;
          if (!fdd_rd_q) begin
            wait_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

`ifdef SD_DISK_HDD_EN
      HDD_REQ: begin
        if (ack_rise) begin
          hdd_rd_d = 1'b0;
          hdd_wr_d = 1'b0;
          rd_clr   = ~serve_wr_q;
          wr_clr   = serve_wr_q;
          state_d  = HDD_DONE;
        end
      end

      HDD_DONE: begin
        if (ack_fall) begin
          wait_d  = 1'b0;
          state_d = IDLE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase

`ifdef SD_DISK_HDD_EN
    // New pulses win over a same-cycle clear so no request is lost.
    rd_pend_d = (rd_pend_q & ~rd_clr) | hdd_read;
    wr_pend_d = (wr_pend_q & ~wr_clr) | hdd_write;
    if (img_mounted[1]) begin
      hdd_mnt_d  = (img_size != 64'd0);
      hdd_prot_d = img_readonly;
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lba_q       <= 32'd0;
      fdd_rd_q    <= 1'b0;
      tsec_q      <= 4'd0;
      wait_q      <= 1'b0;
      cur_track_q <= 6'd0;
      armed_q     <= 1'b0;
      ack_q       <= 1'b0;
`ifdef SD_DISK_HDD_EN
      hdd_rd_q    <= 1'b0;
      hdd_wr_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
      serve_wr_q  <= 1'b0;
      hdd_mnt_q   <= 1'b0;
      hdd_prot_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      lba_q       <= lba_d;
      fdd_rd_q    <= fdd_rd_d;
      tsec_q      <= tsec_d;
      wait_q      <= wait_d;
      cur_track_q <= cur_track_d;
      armed_q     <= armed_d;
      ack_q       <= sd_ack;
`ifdef SD_DISK_HDD_EN
      hdd_rd_q    <= hdd_rd_d;
      hdd_wr_q    <= hdd_wr_d;
      rd_pend_q   <= rd_pend_d;
      wr_pend_q   <= wr_pend_d;
      serve_wr_q  <= serve_wr_d;
      hdd_mnt_q   <= hdd_mnt_d;
      hdd_prot_q  <= hdd_prot_d;
`endif
    end
  end

endmodule

// File: tb/tb_sd_disk_loader.sv
// Testbench for sd_disk_loader: table of single-cycle vectors for the mount
// sequence, then hand-written track-load, mid-load track change, reset and HDD
// sequences with hand-computed expected values.
module tb_sd_disk_loader;

  localparam int SPT = 13;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [1:0]  img_mounted;
  logic        img_readonly;
  logic [63:0] img_size;
  logic [5:0]  track;
  logic [15:0] hdd_sector;
  logic        hdd_read;
  logic        hdd_write;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd;
  logic [1:0]  sd_wr;
  logic [3:0]  track_sec;
  logic        cpu_wait;
  logic        hdd_mounted;
  logic        hdd_protect;

  int checks = 0;
  int errors = 0;

  sd_disk_loader #(.SECTORS_PER_TRACK(SPT)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .img_mounted (img_mounted),
    .img_readonly(img_readonly),
    .img_size    (img_size),
    .track       (track),
    .hdd_sector  (hdd_sector),
    .hdd_read    (hdd_read),
    .hdd_write   (hdd_write),
    .sd_ack      (sd_ack),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .track_sec   (track_sec),
    .cpu_wait    (cpu_wait),
    .hdd_mounted (hdd_mounted),
    .hdd_protect (hdd_protect)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [1:0]  mnt;
    logic [63:0] size;
    logic [5:0]  trk;
    logic        ack;
    logic [31:0] lba;
    logic [1:0]  rd;
    logic [3:0]  ts;
    logic        cw;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Drives sectors [from, upto) of a track load whose first LBA is base.
  task automatic ack_pairs(input int base, input int from, input int upto, input string tag);
    for (int s = from; s < upto; s++) begin
      sd_ack = 1'b1;
      tick();
      chk({tag, "_lba"}, 64'(sd_lba), 64'(base + s + 1));
      chk({tag, "_rd"}, 64'(sd_rd), (s == SPT - 1) ? 64'd0 : 64'd1);
      sd_ack = 1'b0;
      tick();
      chk({tag, "_tsec"}, 64'(track_sec), 64'(s + 1));
      chk({tag, "_wait"}, 64'(cpu_wait), (s == SPT - 1) ? 64'd0 : 64'd1);
    end
  endtask

  initial begin
    vecs[0] = '{mnt: 2'b00, size: 64'd0,      trk: 6'd7, ack: 1'b0, lba: 32'd0, rd: 2'b00, ts: 4'd0, cw: 1'b0};
    vecs[1] = '{mnt: 2'b00, size: 64'd143360, trk: 6'd7, ack: 1'b0, lba: 32'd0, rd: 2'b00, ts: 4'd0, cw: 1'b0};
    vecs[2] = '{mnt: 2'b00, size: 64'd0,      trk: 6'd0, ack: 1'b0, lba: 32'd0, rd: 2'b00, ts: 4'd0, cw: 1'b0};
    vecs[3] = '{mnt: 2'b00, size: 64'd143360, trk: 6'd0, ack: 1'b0, lba: 32'd0, rd: 2'b00, ts: 4'd0, cw: 1'b0};
    vecs[4] = '{mnt: 2'b01, size: 64'd143360, trk: 6'd0, ack: 1'b0, lba: 32'd0, rd: 2'b00, ts: 4'd0, cw: 1'b0};
    vecs[5] = '{mnt: 2'b00, size: 64'd143360, trk: 6'd0, ack: 1'b0, lba: 32'd0, rd: 2'b01, ts: 4'd0, cw: 1'b1};

    reset_n      = 1'b0;
    img_mounted  = 2'b00;
    img_readonly = 1'b0;
    img_size     = 64'd0;
    track        = 6'd0;
    hdd_sector   = 16'd0;
    hdd_read     = 1'b0;
    hdd_write    = 1'b0;
    sd_ack       = 1'b0;
    tick();
    tick();
    chk("rst_lba", 64'(sd_lba), 64'd0);
    chk("rst_rd", 64'(sd_rd), 64'd0);
    chk("rst_wr", 64'(sd_wr), 64'd0);
    chk("rst_tsec", 64'(track_sec), 64'd0);
    chk("rst_wait", 64'(cpu_wait), 64'd0);
    chk("rst_hmnt", 64'(hdd_mounted), 64'd0);
    chk("rst_hprot", 64'(hdd_protect), 64'd0);
    reset_n = 1'b1;

    // Zero-size track change, then floppy mount strobe starting a track 0 load.
    for (int i = 0; i < 6; i++) begin
      img_mounted = vecs[i].mnt;
      img_size    = vecs[i].size;
      track       = vecs[i].trk;
      sd_ack      = vecs[i].ack;
      tick();
      chk($sformatf("vec%0d_lba", i), 64'(sd_lba), 64'(vecs[i].lba));
      chk($sformatf("vec%0d_rd", i), 64'(sd_rd), 64'(vecs[i].rd));
      chk($sformatf("vec%0d_tsec", i), 64'(track_sec), 64'(vecs[i].ts));
      chk($sformatf("vec%0d_wait", i), 64'(cpu_wait), 64'(vecs[i].cw));
    end
    ack_pairs(0, 0, SPT, "mount");

    // Track 0 -> 5.
    track = 6'd5;
    tick();
    chk("trk5_first_lba", 64'(sd_lba), 64'd65);
    chk("trk5_first_rd", 64'(sd_rd), 64'd1);
    chk("trk5_first_tsec", 64'(track_sec), 64'd0);
    chk("trk5_first_wait", 64'(cpu_wait), 64'd1);
    ack_pairs(65, 0, SPT, "trk5");

    // Track 3 load with the head moving to 4 mid-load.
    track = 6'd3;
    tick();
    chk("trk3_first_lba", 64'(sd_lba), 64'd39);
    ack_pairs(39, 0, 4, "trk3a");
    track = 6'd4;
    ack_pairs(39, 4, SPT, "trk3b");
    tick();
    chk("trk4_first_lba", 64'(sd_lba), 64'd52);
    chk("trk4_first_rd", 64'(sd_rd), 64'd1);
    chk("trk4_first_wait", 64'(cpu_wait), 64'd1);
    ack_pairs(52, 0, SPT, "trk4");

    // Reset asserted during sector 6 of a track 2 load.
    track = 6'd2;
    tick();
    chk("trk2_first_lba", 64'(sd_lba), 64'd26);
    ack_pairs(26, 0, 6, "trk2");
    sd_ack = 1'b1;
    tick();
    chk("sec6_lba", 64'(sd_lba), 64'd33);
    chk("sec6_rd", 64'(sd_rd), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_rd", 64'(sd_rd), 64'd0);
    chk("midrst_wait", 64'(cpu_wait), 64'd0);
    chk("midrst_lba", 64'(sd_lba), 64'd0);
    sd_ack = 1'b0;
    tick();
    tick();
    chk("inrst_lba", 64'(sd_lba), 64'd0);
    chk("inrst_rd", 64'(sd_rd), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("reload_lba", 64'(sd_lba), 64'd26);
    chk("reload_rd", 64'(sd_rd), 64'd1);
    chk("reload_wait", 64'(cpu_wait), 64'd1);
    chk("reload_tsec", 64'(track_sec), 64'd0);
    ack_pairs(26, 0, SPT, "reload");

`ifdef SD_DISK_HDD_EN
    // Simultaneous read and write: read served first, write stays pending.
    hdd_sector = 16'h1234;
    hdd_read   = 1'b1;
    hdd_write  = 1'b1;
    tick();
    hdd_read   = 1'b0;
    hdd_write  = 1'b0;
    chk("hdd_latch_rd", 64'(sd_rd), 64'd0);
    tick();
    chk("hdd_rd_req", 64'(sd_rd), 64'h2);
    chk("hdd_rd_wr", 64'(sd_wr), 64'h0);
    chk("hdd_rd_lba", 64'(sd_lba), 64'h1234);
    chk("hdd_rd_wait", 64'(cpu_wait), 64'd1);
    sd_ack = 1'b1;
    tick();
    chk("hdd_rd_ack_rd", 64'(sd_rd), 64'd0);
    chk("hdd_rd_ack_wait", 64'(cpu_wait), 64'd1);
    sd_ack = 1'b0;
    tick();
    chk("hdd_rd_done_wait", 64'(cpu_wait), 64'd0);
    tick();
    chk("hdd_wr_req", 64'(sd_wr), 64'h2);
    chk("hdd_wr_rd", 64'(sd_rd), 64'h0);
    chk("hdd_wr_lba", 64'(sd_lba), 64'h1234);
    chk("hdd_wr_wait", 64'(cpu_wait), 64'd1);
    sd_ack = 1'b1;
    tick();
    chk("hdd_wr_ack_wr", 64'(sd_wr), 64'd0);
    sd_ack = 1'b0;
    tick();
    chk("hdd_wr_done_wait", 64'(cpu_wait), 64'd0);
    tick();
    chk("hdd_idle_rd", 64'(sd_rd), 64'd0);
    chk("hdd_idle_wr", 64'(sd_wr), 64'd0);
    chk("hdd_idle_wait", 64'(cpu_wait), 64'd0);

    // HDD mount status.
    img_mounted  = 2'b10;
    img_size     = 64'd0;
    img_readonly = 1'b1;
    tick();
    img_mounted  = 2'b00;
    chk("hmnt0_mounted", 64'(hdd_mounted), 64'd0);
    chk("hmnt0_protect", 64'(hdd_protect), 64'd1);
    img_mounted  = 2'b10;
    img_size     = 64'd143360;
    img_readonly = 1'b0;
    tick();
    img_mounted  = 2'b00;
    chk("hmnt1_mounted", 64'(hdd_mounted), 64'd1);
    chk("hmnt1_protect", 64'(hdd_protect), 64'd0);
`else
    // HDD inputs must have no effect.
    hdd_sector = 16'h1234;
    hdd_read   = 1'b1;
    hdd_write  = 1'b1;
    tick();
    hdd_read   = 1'b0;
    hdd_write  = 1'b0;
    tick();
    tick();
    tick();
    chk("nohdd_rd", 64'(sd_rd), 64'd0);
    chk("nohdd_wr", 64'(sd_wr), 64'd0);
    chk("nohdd_wait", 64'(cpu_wait), 64'd0);
    chk("nohdd_lba", 64'(sd_lba), 64'd39);
    img_mounted  = 2'b10;
    img_readonly = 1'b1;
    tick();
    img_mounted  = 2'b00;
    chk("nohdd_mounted", 64'(hdd_mounted), 64'd0);
    chk("nohdd_protect", 64'(hdd_protect), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_disk_loader.md
SD_DISK_LOADER -- requirements
Module: sd_disk_loader

Interface
REQ-001 SHALL have parameter SECTORS_PER_TRACK, default 13, giving the number of 512-byte SD sectors per floppy track (13 x 512 = 6656-byte NIB track).
REQ-002 SHALL have ports `clk_sys` (input, 1 bit): system clock; all logic in this single domain.
REQ-003 SHALL have port `reset_n` (input, 1 bit): reset, asynchronous assert, active-low.
REQ-004 SHALL have port `img_mounted` (input, 2 bits): mount strobes from hps_io; bit0 is floppy, bit1 is HDD.
REQ-005 SHALL have port `img_readonly` (input, 1 bit): read-only flag of the image being mounted.
REQ-006 SHALL have port `img_size` (input, 64 bits): byte size of the image being mounted; zero means unmounted.
REQ-007 SHALL have port `track` (input, 6 bits): floppy head track requested by the drive emulation.
REQ-008 SHALL have port `hdd_sector` (input, 16 bits): HDD block number.
REQ-009 SHALL have ports `hdd_read` and `hdd_write` (input, 1 bit each): single-cycle HDD request pulses.
REQ-010 SHALL have port `sd_ack` (input, 1 bit): hps_io transfer acknowledge; high for the duration of one sector transfer.
REQ-011 SHALL have port `sd_lba` (output, 32 bits): SD block address.
REQ-012 SHALL have ports `sd_rd` and `sd_wr` (output, 2 bits each): per-drive request; bit0 is floppy, bit1 is HDD.
REQ-013 SHALL have port `track_sec` (output, 4 bits): sector index within the track, forming the upper bits of the track buffer address.
REQ-014 SHALL have port `cpu_wait` (output, 1 bit): stalls the CPU while a transfer is in flight.
REQ-015 SHALL have ports `hdd_mounted` and `hdd_protect` (output, 1 bit each): HDD mount status and write-protect status.

Function
REQ-016 SHALL implement FSM states IDLE, FDD_LOAD, HDD_REQ and HDD_DONE.
REQ-017 SHALL latch `hdd_read` and `hdd_write` into separate pending flags that are independent of FSM state, so that no pulse is lost while busy.
REQ-018 SHALL register `fdd_armed`, set while `img_mounted[0]` is high; a load SHALL trigger on the falling edge of that signal with `fdd_armed` set, then clear `fdd_armed`.
REQ-019 SHALL apply this priority in IDLE: read-pending, then write-pending, then floppy trigger; only one request is served per IDLE visit.
REQ-020 SHALL define the floppy trigger as (`cur_track` != `track`) or a mount falling edge; on trigger, `cur_track` <= `track`.
REQ-021 SHALL, when `img_size` is zero at the floppy trigger, update `cur_track`, remain in IDLE, and leave `cpu_wait` low.
REQ-022 SHALL, on FDD_LOAD entry, set `sd_lba` to `track` x SECTORS_PER_TRACK (32-bit, zero-extended), set `track_sec` to 0, set `sd_rd` to 01, and set `cpu_wait` to 1.
REQ-023 SHALL, in FDD_LOAD on an `sd_ack` rising edge, increment `sd_lba`; if `track_sec` >= SECTORS_PER_TRACK-1, it SHALL also clear `sd_rd`.
REQ-024 SHALL, in FDD_LOAD on an `sd_ack` falling edge, increment `track_sec`; if `sd_rd[0]` is 0, it SHALL also clear `cpu_wait` and go to IDLE.
REQ-025 SHALL, on HDD_REQ entry, set `sd_lba` to {16'h0, `hdd_sector`}, set `cpu_wait` to 1, and set `sd_rd` to 10 for a read or `sd_wr` to 10 for a write.
REQ-026 SHALL, in HDD_REQ on an `sd_ack` rise, clear `sd_rd`/`sd_wr` and the served pending flag, then go to HDD_DONE.
REQ-027 SHALL, in HDD_DONE on an `sd_ack` fall, clear `cpu_wait` and go to IDLE.
REQ-028 SHALL, when `hdd_read` and `hdd_write` arrive in the same cycle, serve the read first while the write stays pending.
REQ-029 SHALL, on a track change during FDD_LOAD, complete the current load; IDLE then detects the mismatch and reloads.
REQ-030 SHALL, on an `img_mounted[1]` pulse in any state, set `hdd_mounted` <= (`img_size` != 0) and `hdd_protect` <= `img_readonly`.
REQ-031 SHALL detect edges from a registered copy of `sd_ack`.

Reset
REQ-032 SHALL, while `reset_n` is low, asynchronously force: state IDLE; `sd_lba`=0; `sd_rd`=0; `sd_wr`=0; `track_sec`=0; `cpu_wait`=0; `hdd_mounted`=0; `hdd_protect`=0; all pending flags, `fdd_armed` and the registered `sd_ack` cleared; `cur_track`=0.
REQ-033 SHALL, when reset asserts mid-transfer, drop the request immediately; the post-reset IDLE reloads the track if `track` != 0.

Configuration
REQ-034 SHALL, with macro SD_DISK_HDD_EN defined, include the HDD path (REQ-017, REQ-025 to REQ-028, REQ-030).
REQ-035 SHALL, without SD_DISK_HDD_EN, ignore the HDD inputs, tie `sd_rd[1]`, `sd_wr`, `hdd_mounted` and `hdd_protect` to 0, and omit the HDD states.

Verification
REQ-036 SHALL verify this scenario: `img_size`=143360 and `img_mounted[0]` pulse -> `sd_lba`=0, `sd_rd`=01, 13 ack pulses, `track_sec` ends at 13, `cpu_wait` falls after the 13th ack fall.
REQ-037 SHALL verify this scenario: `track` 0->5 -> first `sd_lba`=65, final `sd_lba`=78.
REQ-038 SHALL verify this scenario: `hdd_read` and `hdd_write` in the same cycle with `hdd_sector`=0x1234 -> read (`sd_rd`=10, `sd_lba`=0x1234) then write (`sd_wr`=10).
REQ-039 SHALL verify this scenario: `track` changes 3->4 mid-load -> track 3 finishes, then `sd_lba`=52 load follows.
REQ-040 SHALL verify this scenario: `img_mounted[1]` with `img_size`=0 and `img_readonly`=1 -> `hdd_mounted`=0, `hdd_protect`=1.
REQ-041 SHALL verify this scenario: `reset_n` low during sector 6 -> `sd_rd`=0 and `cpu_wait`=0 the same cycle, no further `sd_lba` change.
